// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter
//   Round-robin arbiter that shares the single Sysbus master port among
//   NUM_CLIENTS clients. Exactly one complete transaction is carried at a
//   time: an address transfer, followed by either BEATS write-data beats
//   (tag MSB set) or BEATS response beats that are routed back to the
//   granted client.
//
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   cl_reqcyc / cl_req / cl_reqtag   per-client request (client i at slice i)
//   cl_reqack                    per-client request accept
//   cl_respcyc                   per-client response valid
//   cl_resp / cl_resptag         response data / tag, broadcast to all clients
//   cl_respack                   per-client response accept
//   bus_reqcyc/req/reqtag/reqack     request side of the Sysbus master port
//   bus_respcyc/resp/resptag/respack response side of the Sysbus master port
//   grant_id                     currently granted client
//   busy                         high whenever a transaction is in progress
module sysbus_arbiter #(
    parameter int NUM_CLIENTS    = 2,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_CLIENTS-1:0]                 cl_reqcyc,
    input  logic [NUM_CLIENTS*BUS_DATA_WIDTH-1:0]  cl_req,
    input  logic [NUM_CLIENTS*BUS_TAG_WIDTH-1:0]   cl_reqtag,
    output logic [NUM_CLIENTS-1:0]                 cl_reqack,
    output logic [NUM_CLIENTS-1:0]                 cl_respcyc,
    output logic [BUS_DATA_WIDTH-1:0]              cl_resp,
    output logic [BUS_TAG_WIDTH-1:0]               cl_resptag,
    input  logic [NUM_CLIENTS-1:0]                 cl_respack,
    output logic                                   bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]              bus_req,
    output logic [BUS_TAG_WIDTH-1:0]               bus_reqtag,
    input  logic                                   bus_reqack,
    input  logic                                   bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]              bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]               bus_resptag,
    output logic                                   bus_respack,
    output logic [$clog2(NUM_CLIENTS)-1:0]         grant_id,
    output logic                                   busy
);

    localparam int GW = $clog2(NUM_CLIENTS);
    localparam int CW = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {IDLE, ADDR, WDATA, RESP} state_t;

    state_t              state, state_nx;
    logic [GW-1:0]       grant, grant_nx;
    logic [GW-1:0]       rr, rr_nx;
    logic [CW-1:0]       cnt, cnt_nx;

    logic [NUM_CLIENTS-1:0]     grant_oh;
    logic                       sel_cyc;
    logic                       sel_respack;
    logic [BUS_DATA_WIDTH-1:0]  sel_req;
    logic [BUS_TAG_WIDTH-1:0]   sel_tag;
    logic                       last_beat;

    // Picks the requester closest after 'last' in circular order, so the
    // client that finished most recently has the lowest priority.
    function automatic logic [GW-1:0] pick(input logic [NUM_CLIENTS-1:0] reqs,
                                           input logic [GW-1:0]          last);
        logic [GW-1:0] win;
        int            best_d;
        int            d;
        win    = last;
        best_d = NUM_CLIENTS;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            d = (i + NUM_CLIENTS - 1 - int'(last)) % NUM_CLIENTS;
            if (reqs[i] && d < best_d) begin
                best_d = d;
                win    = GW'(i);
            end
        end
        return win;
    endfunction

    // Granted client's request slice and response accept.
    always_comb begin
        grant_oh    = '0;
        sel_cyc     = 1'b0;
        sel_respack = 1'b0;
        sel_req     = '0;
        sel_tag     = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant == GW'(i)) begin
                grant_oh[i] = 1'b1;
                sel_cyc     = cl_reqcyc[i];
                sel_respack = cl_respack[i];
                sel_req     = cl_req[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
                sel_tag     = cl_reqtag[i*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
            end
        end
    end

    assign last_beat = (cnt == CW'(BEATS - 1));

    always_comb begin
        state_nx    = state;
        grant_nx    = grant;
        rr_nx       = rr;
        cnt_nx      = cnt;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        cl_reqack   = '0;
        cl_respcyc  = '0;
        cl_resp     = '0;
        cl_resptag  = '0;
        case (state)
            IDLE: begin
                if (|cl_reqcyc) begin
                    grant_nx = pick(cl_reqcyc, rr);
                    cnt_nx   = '0;
                    state_nx = ADDR;
                end
            end
            ADDR, WDATA: begin
                bus_reqcyc = sel_cyc;
                bus_req    = sel_req;
                bus_reqtag = sel_tag;
                cl_reqack  = grant_oh & {NUM_CLIENTS{bus_reqack}};
                if (sel_cyc && bus_reqack) begin
                    if (state == ADDR) begin
                        state_nx = sel_tag[BUS_TAG_WIDTH-1] ? WDATA : RESP;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                        if (last_beat) begin
                            rr_nx    = grant;
                            state_nx = IDLE;
                        end
                    end
                end
            end
            RESP: begin
                cl_respcyc  = grant_oh & {NUM_CLIENTS{bus_respcyc}};
                bus_respack = sel_respack;
                cl_resp     = bus_resp;
                cl_resptag  = bus_resptag;
                if (bus_respcyc && sel_respack) begin
                    cnt_nx = cnt + CW'(1);
                    if (last_beat) begin
                        rr_nx    = grant;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            rr    <= GW'(NUM_CLIENTS - 1);
            cnt   <= '0;
        end else begin
            state <= state_nx;
            grant <= grant_nx;
            rr    <= rr_nx;
            cnt   <= cnt_nx;
        end
    end

    assign grant_id = grant;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Testbench for sysbus_arbiter (3 clients, 8 beats). Client and bus models
// generate traffic and push expected words into scoreboard queues; a
// separate monitor predicts grants with a transaction-level round-robin
// model and checks every DUT output against those queues.
module tb_sysbus_arbiter;

    localparam int N  = 3;
    localparam int DW = 64;
    localparam int TW = 13;
    localparam int B  = 8;
    localparam int GW = 2;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0]    cl_reqcyc, cl_reqack, cl_respcyc, cl_respack;
    logic [N*DW-1:0] cl_req;
    logic [N*TW-1:0] cl_reqtag;
    logic [DW-1:0]   cl_resp, bus_req, bus_resp;
    logic [TW-1:0]   cl_resptag, bus_reqtag, bus_resptag;
    logic            bus_reqcyc, bus_reqack, bus_respcyc, bus_respack, busy;
    logic [GW-1:0]   grant_id;

    sysbus_arbiter #(.NUM_CLIENTS(N), .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(B)) dut (
        .clk(clk), .reset(reset),
        .cl_reqcyc(cl_reqcyc), .cl_req(cl_req), .cl_reqtag(cl_reqtag), .cl_reqack(cl_reqack),
        .cl_respcyc(cl_respcyc), .cl_resp(cl_resp), .cl_resptag(cl_resptag), .cl_respack(cl_respack),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Scoreboard queues
    logic [DW-1:0]    exp_bus [N][$];
    logic [TW-1:0]    exp_tag [N][$];
    logic [DW+TW-1:0] exp_resp[$];
    int               got_grants[$];

    // Client models
    bit            c_act [N];
    bit            c_w   [N];
    bit            c_auto[N];
    int            c_k   [N];
    int            c_rx  [N];
    logic [DW-1:0] c_words[N][B+1];
    logic [TW-1:0] c_tag [N];

    // Bus slave model
    int            s_wleft, s_rleft, s_beat;
    bit            s_valid, s_fixed;
    logic [DW-1:0] s_data;
    logic [TW-1:0] s_tag;

    int issue_pct, ack_pct, resp_pct, rack_pct, drop_pct;

    task automatic new_txn(input int i, input bit w, input logic [DW-1:0] addr,
                           input logic [TW-1:0] tag, input logic [DW-1:0] dbase, input bit rnd);
        c_words[i][0] = addr;
        for (int b = 1; b <= B; b++)
            c_words[i][b] = rnd ? {$urandom, $urandom} : dbase + 64'(b - 1);
        exp_bus[i].push_back(addr);
        if (w)
            for (int b = 1; b <= B; b++) exp_bus[i].push_back(c_words[i][b]);
        exp_tag[i].push_back(tag);
        c_tag[i] = tag;
        c_w[i]   = w;
        c_k[i]   = 0;
        c_rx[i]  = 0;
        c_act[i] = 1'b1;
    endtask

    task automatic clear_env();
        for (int i = 0; i < N; i++) begin
            c_act[i] = 1'b0; c_auto[i] = 1'b0; c_k[i] = 0; c_rx[i] = 0;
            exp_bus[i].delete();
            exp_tag[i].delete();
        end
        exp_resp.delete();
        s_wleft = 0; s_rleft = 0; s_beat = 0; s_valid = 1'b0;
        s_data = '0; s_tag = '0;
        cl_reqcyc = '0; cl_req = '0; cl_reqtag = '0; cl_respack = '0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    endtask

    // Drive all model outputs just after the rising edge
    task automatic drive();
        bit w;
        for (int i = 0; i < N; i++) begin
            if (!c_act[i] && c_auto[i] && $urandom_range(99) < issue_pct) begin
                w = 1'($urandom_range(1));
                new_txn(i, w, {$urandom, $urandom}, {w, 12'($urandom)}, '0, 1'b1);
            end
            if (c_act[i] && c_k[i] <= (c_w[i] ? B : 0)) begin
                cl_reqcyc[i] = ($urandom_range(99) >= drop_pct);
                cl_req[i*DW +: DW]    = c_words[i][c_k[i]];
                cl_reqtag[i*TW +: TW] = c_tag[i];
            end else begin
                cl_reqcyc[i] = 1'b0;
                cl_req[i*DW +: DW]    = {$urandom, $urandom};
                cl_reqtag[i*TW +: TW] = 13'($urandom);
            end
            cl_respack[i] = ($urandom_range(99) < rack_pct);
        end
        bus_reqack = ($urandom_range(99) < ack_pct);
        if (!s_valid && s_rleft > 0 && $urandom_range(99) < resp_pct) begin
            s_data  = s_fixed ? 64'(160 + s_beat) : {$urandom, $urandom};
            s_tag   = 13'($urandom);
            s_beat++;
            s_valid = 1'b1;
            exp_resp.push_back({s_tag, s_data});
        end
        bus_respcyc = s_valid;
        bus_resp    = s_data;
        bus_resptag = s_tag;
    endtask

    // Observe handshakes at the falling edge to advance the models
    task automatic sample();
        for (int i = 0; i < N; i++) begin
            if (c_act[i]) begin
                if (cl_reqcyc[i] && cl_reqack[i]) c_k[i]++;
                if (cl_respcyc[i] && cl_respack[i]) c_rx[i]++;
                if (c_w[i] ? (c_k[i] > B) : (c_rx[i] == B)) c_act[i] = 1'b0;
            end
        end
        if (bus_reqcyc && bus_reqack) begin
            if (s_wleft > 0) s_wleft--;
            else if (bus_reqtag[TW-1]) s_wleft = B;
            else begin s_rleft = B; s_beat = 0; end
        end
        if (bus_respcyc && bus_respack) begin
            s_valid = 1'b0;
            s_rleft--;
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        drive();
        @(negedge clk);
        sample();
    endtask

    function automatic bit env_idle();
        bit idle;
        idle = (s_rleft == 0) && !s_valid && (s_wleft == 0);
        for (int i = 0; i < N; i++) if (c_act[i]) idle = 1'b0;
        return idle;
    endfunction

    task automatic run_until_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!env_idle() && n < budget) begin
            step();
            n++;
        end
        chk(name, env_idle(), 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        clear_env();
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Monitor: transaction-level reference model and output checks
    int   m_rr, m_g, m_phase, m_cnt;
    bit   m_pend, m_in;
    logic [DW-1:0]    ew;
    logic [TW-1:0]    et;
    logic [DW+TW-1:0] er;
    logic [N-1:0]     oh;

    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                m_rr = N - 1; m_pend = 1'b0; m_in = 1'b0;
            end else begin
                if (m_pend) begin
                    chk("grant_busy", busy, 1);
                    chk("grant_id", grant_id, m_g);
                    got_grants.push_back(int'(grant_id));
                    m_pend = 1'b0; m_in = 1'b1; m_phase = 0; m_cnt = 0;
                end
                if (m_in) begin
                    oh = '0;
                    oh[m_g] = 1'b1;
                    chk("busy_in_txn", busy, 1);
                    chk("grant_stable", grant_id, m_g);
                    if (m_phase != 2) begin
                        chk("bus_reqcyc_pass", bus_reqcyc, cl_reqcyc[m_g]);
                        chk("cl_reqack_route", cl_reqack, oh & {N{bus_reqack}});
                        chk("respack_quiet_req", bus_respack, 0);
                        chk("respcyc_quiet_req", cl_respcyc, 0);
                        if (cl_reqcyc[m_g] && bus_reqack) begin
                            if (exp_bus[m_g].size() == 0) fail("bus_req_unexpected");
                            else begin
                                ew = exp_bus[m_g].pop_front();
                                chk("bus_req", bus_req, ew);
                            end
                            if (m_phase == 0) begin
                                if (exp_tag[m_g].size() == 0) fail("bus_reqtag_unexpected");
                                else begin
                                    et = exp_tag[m_g].pop_front();
                                    chk("bus_reqtag", bus_reqtag, et);
                                    m_phase = et[TW-1] ? 1 : 2;
                                end
                            end else begin
                                m_cnt++;
                                if (m_cnt == B) begin m_rr = m_g; m_in = 1'b0; end
                            end
                        end
                    end else begin
                        chk("bus_reqcyc_quiet_resp", bus_reqcyc, 0);
                        chk("cl_reqack_quiet_resp", cl_reqack, 0);
                        chk("cl_respcyc_route", cl_respcyc, oh & {N{bus_respcyc}});
                        chk("bus_respack_pass", bus_respack, cl_respack[m_g]);
                        if (bus_respcyc && cl_respack[m_g]) begin
                            if (exp_resp.size() == 0) fail("resp_unexpected");
                            else begin
                                er = exp_resp.pop_front();
                                chk("cl_resp", {cl_resptag, cl_resp}, er);
                            end
                            m_cnt++;
                            if (m_cnt == B) begin m_rr = m_g; m_in = 1'b0; end
                        end
                    end
                end else if (!m_pend) begin
                    chk("idle_busy", busy, 0);
                    chk("idle_bus_reqcyc", bus_reqcyc, 0);
                    chk("idle_bus_req", bus_req, 0);
                    chk("idle_cl_reqack", cl_reqack, 0);
                    chk("idle_cl_respcyc", cl_respcyc, 0);
                    chk("idle_bus_respack", bus_respack, 0);
                    chk("idle_cl_resp", cl_resp, 0);
                    if (cl_reqcyc != '0) begin
                        for (int k = 1; k <= N; k++) begin
                            if (cl_reqcyc[(m_rr + k) % N]) begin
                                m_g = (m_rr + k) % N;
                                break;
                            end
                        end
                        m_pend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        clear_env();
        issue_pct = 0; ack_pct = 100; resp_pct = 100; rack_pct = 100; drop_pct = 0;
        s_fixed = 1'b0;

        // Reset state, with requests and a response offered during reset
        cl_reqcyc = '1; bus_respcyc = 1'b1; bus_reqack = 1'b1; cl_respack = '1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_bus_reqcyc", bus_reqcyc, 0);
        chk("rst_bus_respack", bus_respack, 0);
        chk("rst_cl_reqack", cl_reqack, 0);
        chk("rst_cl_respcyc", cl_respcyc, 0);
        chk("rst_cl_resp", cl_resp, 0);
        @(posedge clk); #1;
        clear_env();
        reset = 1'b0;

        // Stray bus response while idle
        @(posedge clk); #1;
        bus_respcyc = 1'b1; bus_resp = 64'hBAD; bus_resptag = 13'h1BAD;
        @(negedge clk);
        chk("stray_respack", bus_respack, 0);
        chk("stray_respcyc", cl_respcyc, 0);
        chk("stray_busy", busy, 0);
        step();

        // Single read by client 0, response data 0xA0..0xA7
        s_fixed = 1'b1; ack_pct = 40;
        got_grants.delete();
        new_txn(0, 1'b0, 64'h1000, 13'h0001, '0, 1'b0);
        run_until_idle("single_read_done", 300);
        step();
        chk("single_read_beats", c_rx[0], B);
        chk("single_read_grant", got_grants.size() > 0 ? got_grants[0] : -1, 0);
        chk("single_read_busy_after", busy, 0);

        // Write burst by client 1, then all three contend: rr must now be 1
        got_grants.delete();
        new_txn(1, 1'b1, 64'h2000, 13'h1005, 64'hD0, 1'b0);
        run_until_idle("write_done", 300);
        for (int i = 0; i < N; i++) new_txn(i, 1'b0, 64'h3000 + 64'(i), 13'(i), '0, 1'b1);
        run_until_idle("after_write_done", 600);
        chk("write_grant_cnt", got_grants.size(), 4);
        if (got_grants.size() == 4) begin
            chk("write_grant0", got_grants[0], 1);
            chk("rr_after_write_g1", got_grants[1], 2);
            chk("rr_after_write_g2", got_grants[2], 0);
            chk("rr_after_write_g3", got_grants[3], 1);
        end

        // Response backpressure from client 0
        ack_pct = 100; rack_pct = 40;
        new_txn(0, 1'b0, 64'h4000, 13'h0042, '0, 1'b1);
        run_until_idle("backpressure_done", 400);
        chk("backpressure_beats", c_rx[0], B);

        // Reset in the middle of a response burst
        rack_pct = 100;
        new_txn(0, 1'b0, 64'h5000, 13'h0007, '0, 1'b1);
        n = 0;
        while (c_rx[0] < 4 && n < 200) begin step(); n++; end
        chk("mid_resp_reached", c_rx[0], 4);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_grant_id", grant_id, 0);
        chk("midrst_cl_respcyc", cl_respcyc, 0);
        chk("midrst_bus_respack", bus_respack, 0);
        chk("midrst_cl_resp", cl_resp, 0);
        chk("midrst_bus_reqcyc", bus_reqcyc, 0);
        clear_env();
        @(posedge clk); #1;
        reset = 1'b0;
        got_grants.delete();
        new_txn(1, 1'b0, 64'h6000, 13'h0009, '0, 1'b1);
        run_until_idle("post_reset_read_done", 300);
        chk("post_reset_grant", got_grants.size() > 0 ? got_grants[0] : -1, 1);

        // Continuous contention from reset: grants 0,1,2,0
        do_reset();
        got_grants.delete();
        issue_pct = 100;
        for (int i = 0; i < N; i++) c_auto[i] = 1'b1;
        n = 0;
        while (got_grants.size() < 4 && n < 600) begin step(); n++; end
        chk("contention_grant_cnt", got_grants.size() >= 4, 1);
        if (got_grants.size() >= 4) begin
            chk("contention_g0", got_grants[0], 0);
            chk("contention_g1", got_grants[1], 1);
            chk("contention_g2", got_grants[2], 2);
            chk("contention_g3", got_grants[3], 0);
        end
        for (int i = 0; i < N; i++) c_auto[i] = 1'b0;
        run_until_idle("contention_drain", 1000);

        // Randomized traffic with request drops and backpressure everywhere
        s_fixed = 1'b0;
        issue_pct = 30; ack_pct = 60; resp_pct = 60; rack_pct = 70; drop_pct = 10;
        for (int i = 0; i < N; i++) c_auto[i] = 1'b1;
        repeat (3000) step();
        for (int i = 0; i < N; i++) c_auto[i] = 1'b0;
        run_until_idle("random_drain", 3000);
        step();
        for (int i = 0; i < N; i++) begin
            chk("exp_bus_empty", exp_bus[i].size(), 0);
            chk("exp_tag_empty", exp_tag[i].size(), 0);
        end
        chk("exp_resp_empty", exp_resp.size(), 0);
        chk("final_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
